// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a pending-producer scoreboard.
//
// Storage is 2**ADDR_W entries of DATA_W bits. Entry 0 reads as zero, ignores writes and
// is never pending. There are two combinational read ports with same-cycle write bypass
// and one byte-enabled synchronous write port.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset that clears all state
//   wE, rW, busW     write enable, write address and write data
//   wBE              byte-lane write enables (lane i = bits 8i+7:8i)
//   rA, rB           read addresses
//   busA, busB       read data, with the bypass merged in
//   iss_en, iss_rd   issue strobe and destination register of the issuing instruction
//   busyA, busyB     addressed register waits on a producer not yet written back
//   pend_cnt         registered count of the pending bits
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wE,
  input  logic [ADDR_W-1:0]   rW,
  input  logic [DATA_W-1:0]   busW,
  input  logic [DATA_W/8-1:0] wBE,
  input  logic [ADDR_W-1:0]   rA,
  input  logic [ADDR_W-1:0]   rB,
  output logic [DATA_W-1:0]   busA,
  output logic [DATA_W-1:0]   busB,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic                busyA,
  output logic                busyB,
  output logic [ADDR_W:0]     pend_cnt
);

  localparam int unsigned NBE   = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              wb_valid, iss_valid;
  logic              set_new, clr_eff;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] wr_data, byp_a, byp_b;

  assign wb_valid  = wE && (rW != '0);
  assign iss_valid = iss_en && (iss_rd != '0);

  // Lane merge of busW over the stored entry, shared by the write path and both bypasses.
  always_comb begin
    wr_data = mem_q[rW];
    byp_a   = mem_q[rA];
    byp_b   = mem_q[rB];
    for (int unsigned i = 0; i < NBE; i++) begin
      if (wBE[i]) begin
        wr_data[8*i +: 8] = busW[8*i +: 8];
        byp_a[8*i +: 8]   = busW[8*i +: 8];
        byp_b[8*i +: 8]   = busW[8*i +: 8];
      end
    end
  end

  assign hit_a = wE && (rW == rA);
  assign hit_b = wE && (rW == rB);

  always_comb begin
    busA = '0;
    busB = '0;
    if (rA != '0) busA = hit_a ? byp_a : mem_q[rA];
    if (rB != '0) busB = hit_b ? byp_b : mem_q[rB];
  end

  // A writeback in this cycle satisfies the read via the bypass, so it is not busy.
  assign busyA = (rA != '0) && pend_q[rA] && !hit_a;
  assign busyB = (rB != '0) && pend_q[rB] && !hit_b;

  // Issue is applied after writeback so a same-edge issue to rW leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid)  pend_d[rW]     = 1'b0;
    if (iss_valid) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Incremental update keeps cnt_q equal to popcount(pend_q) without an adder tree.
  assign set_new = iss_valid && !pend_q[iss_rd];
  assign clr_eff = wb_valid && pend_q[rW] && !(iss_valid && (iss_rd == rW));
  assign cnt_d   = cnt_q + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_eff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wb_valid) mem_q[rW] <= wr_data;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb. The stimulus process drives inputs just
// after each rising edge and queues the expected outputs; a monitor pops the queue on each
// falling edge and compares against the DUT.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        wE;
  logic [4:0]  rW;
  logic [31:0] busW;
  logic [3:0]  wBE;
  logic [4:0]  rA, rB;
  logic [31:0] busA, busB;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        busyA, busyB;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          ca;
    logic [31:0] a;
    bit          cb;
    logic [31:0] b;
    bit          cy;
    logic        ya;
    logic        yb;
    bit          cc;
    logic [5:0]  c;
  } exp_t;

  exp_t exp_q[$];

  regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wE       (wE),
    .rW       (rW),
    .busW     (busW),
    .wBE      (wBE),
    .rA       (rA),
    .rB       (rB),
    .busA     (busA),
    .busB     (busB),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busyA    (busyA),
    .busyB    (busyB),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.ca) cmp({e.name, ".busA"}, busA, e.a);
      if (e.cb) cmp({e.name, ".busB"}, busB, e.b);
      if (e.cy) begin
        cmp({e.name, ".busyA"}, {31'd0, busyA}, {31'd0, e.ya});
        cmp({e.name, ".busyB"}, {31'd0, busyB}, {31'd0, e.yb});
      end
      if (e.cc) cmp({e.name, ".pend_cnt"}, {26'd0, pend_cnt}, {26'd0, e.c});
    end
  end

  task automatic expect_out(input string name,
                            input bit ca, input logic [31:0] a,
                            input bit cb, input logic [31:0] b,
                            input bit cy, input logic ya, input logic yb,
                            input bit cc, input logic [5:0] c);
    exp_t e;
    e.name = name; e.ca = ca; e.a = a; e.cb = cb; e.b = b;
    e.cy = cy; e.ya = ya; e.yb = yb; e.cc = cc; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wE = 1'b0; rW = '0; busW = '0; wBE = '0; iss_en = 1'b0; iss_rd = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wE = 1'b1; rW = a; busW = d; wBE = be;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en = 1'b1; iss_rd = a;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rA = '0; rB = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state over every entry.
    for (int i = 0; i < 32; i++) begin
      rA = 5'(i); rB = 5'(31 - i);
      expect_out($sformatf("reset_r%0d", i), 1, 32'd0, 1, 32'd0, 1, 1'b0, 1'b0, 1, 6'd0);
      step();
    end

    // Write with full-word bypass, then storage read.
    wr(5'd8, 32'hDEADBEEF, 4'b1111); rA = 5'd8; rB = 5'd0;
    expect_out("wr_bypass", 1, 32'hDEADBEEF, 1, 32'd0, 0, 0, 0, 0, 0);
    step();
    idle();
    expect_out("wr_stored", 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Byte enables: stored 0x11223344 merged with 0xAABBCCDD on lanes 0 and 2.
    wr(5'd9, 32'h11223344, 4'b1111);
    step();
    wr(5'd9, 32'hAABBCCDD, 4'b0101); rA = 5'd9;
    expect_out("be_bypass", 1, 32'h11BB33DD, 0, 0, 0, 0, 0, 0, 0);
    step();
    idle(); rB = 5'd8;
    expect_out("be_stored", 1, 32'h11BB33DD, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();

    // r0 ignores writes and issues.
    wr(5'd0, 32'hFFFFFFFF, 4'b1111); iss(5'd0); rA = 5'd0; rB = 5'd0;
    expect_out("r0_cycle", 1, 32'd0, 1, 32'd0, 1, 1'b0, 1'b0, 1, 6'd0);
    step();
    idle();
    expect_out("r0_after", 1, 32'd0, 0, 0, 1, 1'b0, 1'b0, 1, 6'd0);
    step();

    // Scoreboard.
    iss(5'd5);
    expect_out("sb_iss5", 0, 0, 0, 0, 0, 0, 0, 1, 6'd0);
    step();
    iss(5'd6); rA = 5'd5; rB = 5'd0;
    expect_out("sb_iss6", 0, 0, 0, 0, 1, 1'b1, 1'b0, 1, 6'd1);
    step();
    idle(); rA = 5'd5; rB = 5'd6;
    expect_out("sb_two", 0, 0, 0, 0, 1, 1'b1, 1'b1, 1, 6'd2);
    step();
    wr(5'd5, 32'h55, 4'b1111);
    expect_out("sb_wb5", 1, 32'h55, 0, 0, 1, 1'b0, 1'b1, 1, 6'd2);
    step();
    idle();
    expect_out("sb_after5", 1, 32'h55, 0, 0, 1, 1'b0, 1'b1, 1, 6'd1);
    step();
    iss(5'd6); wr(5'd6, 32'h66, 4'b1111);
    expect_out("sb_same6", 0, 0, 1, 32'h66, 1, 1'b0, 1'b0, 1, 6'd1);
    step();
    idle();
    expect_out("sb_still6", 0, 0, 1, 32'h66, 1, 1'b0, 1'b1, 1, 6'd1);
    step();

    // Writeback with no lanes enabled: data kept, pending cleared.
    wr(5'd6, 32'hFFFFFFFF, 4'b0000);
    expect_out("be0_bypass", 0, 0, 1, 32'h66, 1, 1'b0, 1'b0, 1, 6'd1);
    step();
    idle();
    expect_out("be0_after", 0, 0, 1, 32'h66, 1, 1'b0, 1'b0, 1, 6'd0);
    step();

    // Build up r3=5 and three pending registers; issue and writeback on different registers.
    wr(5'd3, 32'h5, 4'b1111); iss(5'd10);
    step();
    idle(); iss(5'd11);
    step();
    iss(5'd12);
    step();
    wr(5'd10, 32'hA, 4'b1111); iss(5'd13); rA = 5'd3; rB = 5'd10;
    expect_out("mix_before", 1, 32'h5, 1, 32'hA, 1, 1'b0, 1'b0, 1, 6'd3);
    step();
    idle(); rB = 5'd13;
    expect_out("mix_after", 1, 32'h5, 0, 0, 1, 1'b0, 1'b1, 1, 6'd3);
    step();

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    expect_out("arst_now", 1, 32'd0, 0, 0, 1, 1'b0, 1'b0, 1, 6'd0);
    @(negedge clk);
    #1;
    wr(5'd3, 32'h7, 4'b1111); iss(5'd4);
    step();
    idle(); rst_n = 1'b1; rA = 5'd3; rB = 5'd4;
    expect_out("arst_ignored", 1, 32'd0, 0, 0, 1, 1'b0, 1'b0, 1, 6'd0);
    step();
    iss(5'd7);
    step();
    idle(); rA = 5'd7;
    expect_out("arst_release", 0, 0, 0, 0, 1, 1'b1, 1'b0, 1, 6'd1);
    step();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
